// File: rtl/frontend_pkg.sv
// Shared types and constants for the in-order front end.
package frontend_pkg;

   localparam int PC_W_DEFAULT    = 12;
   localparam int INSTR_W_DEFAULT = 32;

   // An all-zero instruction word terminates the program.
   localparam logic [INSTR_W_DEFAULT-1:0] HALT_INSTR = 32'h0;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } fe_state_e;

   // One fetched instruction together with the PC it came from.
   typedef struct packed {
      logic [PC_W_DEFAULT-1:0]    pc;
      logic [INSTR_W_DEFAULT-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/frontend_if.sv
// Bundle of instruction-memory, redirect and decode-side signals of the front end.
interface frontend_if #(
   parameter int PC_W    = 12,
   parameter int INSTR_W = 32
);
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_data;
   logic               redirect_valid;
   logic [PC_W-1:0]    redirect_pc;
   logic               dec_ready;
   logic               dec_valid;
   logic [PC_W-1:0]    dec_pc;
   logic [INSTR_W-1:0] dec_instr;
   logic               halted;
   logic [1:0]         state;

   // Controller side
   modport master (
      output imem_addr,
      input  imem_data,
      input  redirect_valid,
      input  redirect_pc,
      input  dec_ready,
      output dec_valid,
      output dec_pc,
      output dec_instr,
      output halted,
      output state
   );

   // Environment side (memory, back end, decode)
   modport slave (
      input  imem_addr,
      output imem_data,
      output redirect_valid,
      output redirect_pc,
      output dec_ready,
      input  dec_valid,
      input  dec_pc,
      input  dec_instr,
      input  halted,
      input  state
   );
endinterface

// File: rtl/frontend_fetch_queue.sv
// Two-entry synchronous FIFO with a registered head; flush wins over enq/deq.
module fetch_queue
   import frontend_pkg::*;
#(
   parameter type entry_t = fetch_entry_t
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enq_i,
   input  logic       deq_i,
   input  logic       flush_i,
   input  entry_t     entry_i,
   output logic [1:0] count_o,
   output entry_t     head_o
);

   entry_t     slot0_q, slot0_d;
   entry_t     slot1_q, slot1_d;
   logic [1:0] count_q, count_d;
   logic       do_deq;
   logic       do_enq;

   // A full queue only accepts a new entry when the head leaves in the same cycle.
   assign do_deq = deq_i && (count_q != 2'd0);
   assign do_enq = enq_i && ((count_q != 2'd2) || do_deq);

   // Next-state of slots and occupancy; slot0 is always the head and keeps
   // its last value when the queue drains so the decode outputs hold.
   always_comb begin
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      count_d = count_q;
      if (flush_i) begin
         count_d = 2'd0;
      end else begin
         case (count_q)
            2'd0: begin
               if (do_enq) begin
                  slot0_d = entry_i;
                  count_d = 2'd1;
               end
            end
            2'd1: begin
               if (do_enq && do_deq) begin
                  slot0_d = entry_i;
               end else if (do_enq) begin
                  slot1_d = entry_i;
                  count_d = 2'd2;
               end else if (do_deq) begin
                  count_d = 2'd0;
               end
            end
            default: begin
               if (do_deq) begin
                  slot0_d = slot1_q;
                  if (do_enq) begin
                     slot1_d = entry_i;
                  end else begin
                     count_d = 2'd1;
                  end
               end
            end
         endcase
      end
   end

   // Storage and occupancy registers
   always_ff @(posedge clk) begin
      if (rst) begin
         slot0_q <= '0;
         slot1_q <= '0;
         count_q <= 2'd0;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign head_o  = slot0_q;

endmodule

// File: rtl/frontend_ctrl.sv
// Front-end sequencer: PC, fetch FSM, and the decode-side fetch queue.
module frontend_ctrl
   import frontend_pkg::*;
#(
   parameter int          PC_W     = PC_W_DEFAULT,
   parameter int          INSTR_W  = INSTR_W_DEFAULT,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned PC_STEP  = 4
) (
   input logic       clk,
   input logic       rst,
   frontend_if.master bus
);

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   fe_state_e       state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [1:0]      count;
   entry_t          head;
   entry_t          enq_entry;
   logic            deq;
   logic            fetch;
   logic            enq;
   logic            is_halt;
   logic            halted;

   assign deq       = (count != 2'd0) && bus.dec_ready;
   assign is_halt   = (bus.imem_data == INSTR_W'(HALT_INSTR));
   assign enq       = fetch && !is_halt;
   assign enq_entry = '{pc: pc_q, instr: bus.imem_data};

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state; a redirect restarts fetching from any state
   always_comb begin
      state_d = state_q;
      if (bus.redirect_valid) begin
         state_d = ST_RUN;
      end else begin
         unique case (state_q)
            ST_BOOT:   state_d = ST_RUN;
            ST_RUN:    if (fetch && is_halt) state_d = ST_DRAIN;
            ST_DRAIN:  if (count == 2'd0) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
         endcase
      end
   end

   // FSM outputs: fetch strobe and halted flag
   always_comb begin
      fetch  = (state_q == ST_RUN) && !bus.redirect_valid &&
               ((count != 2'd2) || deq);
      halted = (state_q == ST_HALTED);
   end

   // Next PC: redirect target (word aligned), else advance past each enqueued word
   always_comb begin
      pc_d = pc_q;
      if (bus.redirect_valid) begin
         pc_d = {bus.redirect_pc[PC_W-1:2], 2'b00};
      end else if (enq) begin
         pc_d = pc_q + PC_W'(PC_STEP);
      end
   end

   // PC register
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= PC_W'(RESET_PC);
      end else begin
         pc_q <= pc_d;
      end
   end

   fetch_queue #(
      .entry_t (entry_t)
   ) u_fetch_queue (
      .clk     (clk),
      .rst     (rst),
      .enq_i   (enq),
      .deq_i   (deq),
      .flush_i (bus.redirect_valid),
      .entry_i (enq_entry),
      .count_o (count),
      .head_o  (head)
   );

   assign bus.imem_addr = pc_q;
   assign bus.dec_valid = (count != 2'd0);
   assign bus.dec_pc    = head.pc;
   assign bus.dec_instr = head.instr;
   assign bus.halted    = halted;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_frontend_ctrl.sv
// Directed self-checking bench for frontend_ctrl.
module tb_frontend_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   frontend_if #(.PC_W(12), .INSTR_W(32)) bus ();

   logic [31:0] mem [0:1023];
   assign bus.imem_data = mem[bus.imem_addr[11:2]];

   frontend_ctrl #(
      .PC_W     (12),
      .INSTR_W  (32),
      .RESET_PC (0),
      .PC_STEP  (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int passed = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
   endtask

   // Leaves the bench in cycle E0 (BOOT, reset released)
   task automatic do_reset();
      rst = 1'b1;
      bus.redirect_valid = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      clear_mem();
      bus.dec_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 12'h0;
      rst = 1'b1;
      step();
      checks++; if (bus.state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", bus.state); else passed++;
      checks++; if (bus.imem_addr !== 12'h000) $display("FAIL reset_addr got=%h exp=000", bus.imem_addr); else passed++;
      checks++; if (bus.dec_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.dec_valid); else passed++;
      checks++; if (bus.dec_pc !== 12'h000) $display("FAIL reset_dec_pc got=%h exp=000", bus.dec_pc); else passed++;
      checks++; if (bus.dec_instr !== 32'h0) $display("FAIL reset_dec_instr got=%h exp=0", bus.dec_instr); else passed++;
      checks++; if (bus.halted !== 1'b0) $display("FAIL reset_halted got=%b exp=0", bus.halted); else passed++;
      rst = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_stream();
      clear_mem();
      mem[0] = 32'h0050_0093;
      mem[1] = 32'h0010_0113;
      mem[2] = 32'h0;
      bus.dec_ready = 1'b1;
      do_reset();
      checks++; if (bus.state !== 2'd0) $display("FAIL stream_e0_boot got=%0d exp=0", bus.state); else passed++;
      step(); // E1
      checks++; if (bus.state !== 2'd1 || bus.imem_addr !== 12'h000 || bus.dec_valid !== 1'b0)
         $display("FAIL stream_e1 got state=%0d addr=%h valid=%b exp 1/000/0", bus.state, bus.imem_addr, bus.dec_valid); else passed++;
      step(); // E2
      checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 12'h000 || bus.dec_instr !== 32'h0050_0093)
         $display("FAIL stream_e2 got v=%b pc=%h instr=%h exp 1/000/00500093", bus.dec_valid, bus.dec_pc, bus.dec_instr); else passed++;
      step(); // E3
      checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 12'h004 || bus.dec_instr !== 32'h0010_0113)
         $display("FAIL stream_e3 got v=%b pc=%h instr=%h exp 1/004/00100113", bus.dec_valid, bus.dec_pc, bus.dec_instr); else passed++;
      step(); // E4: zero word never enqueued
      checks++; if (bus.dec_valid !== 1'b0 || bus.state !== 2'd2 || bus.halted !== 1'b0)
         $display("FAIL stream_e4 got v=%b state=%0d halted=%b exp 0/2/0", bus.dec_valid, bus.state, bus.halted); else passed++;
      step(); // E5
      checks++; if (bus.halted !== 1'b1 || bus.state !== 2'd3)
         $display("FAIL stream_e5_halted got halted=%b state=%0d exp 1/3", bus.halted, bus.state); else passed++;
      $display("test_stream done");
   endtask

   task automatic test_backpressure();
      clear_mem();
      for (int i = 0; i < 5; i++) mem[i] = 32'h1000_0013 + i;
      mem[5] = 32'h0;
      bus.dec_ready = 1'b0;
      do_reset();   // E0
      step();       // E1
      step();       // E2
      for (int k = 3; k <= 6; k++) begin
         step();
         checks++; if (bus.imem_addr !== 12'h008 || bus.dec_valid !== 1'b1 || bus.dec_pc !== 12'h000)
            $display("FAIL bp_stall_e%0d got addr=%h v=%b pc=%h exp 008/1/000", k, bus.imem_addr, bus.dec_valid, bus.dec_pc); else passed++;
      end
      step();       // E7
      bus.dec_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 12'(i * 4) || bus.dec_instr !== 32'h1000_0013 + i)
            $display("FAIL bp_release_%0d got v=%b pc=%h instr=%h exp 1/%h/%h", i, bus.dec_valid, bus.dec_pc,
                     bus.dec_instr, 12'(i * 4), 32'h1000_0013 + i); else passed++;
         step();
      end
      checks++; if (bus.dec_valid !== 1'b0) $display("FAIL bp_drained got v=%b exp 0", bus.dec_valid); else passed++;
      step();
      checks++; if (bus.halted !== 1'b1) $display("FAIL bp_halted got=%b exp 1", bus.halted); else passed++;
      $display("test_backpressure done");
   endtask

   task automatic test_redirect_full();
      mem[12'h100 >> 2] = 32'hAAAA_0013;
      mem[12'h104 >> 2] = 32'h0;
      bus.dec_ready = 1'b0;
      do_reset();
      step(); step(); step(); // E3: queue full
      checks++; if (bus.dec_valid !== 1'b1 || bus.imem_addr !== 12'h008)
         $display("FAIL rf_full got v=%b addr=%h exp 1/008", bus.dec_valid, bus.imem_addr); else passed++;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 12'h102;
      step();
      bus.redirect_valid = 1'b0;
      checks++; if (bus.dec_valid !== 1'b0 || bus.imem_addr !== 12'h100 || bus.state !== 2'd1)
         $display("FAIL rf_n1 got v=%b addr=%h state=%0d exp 0/100/1", bus.dec_valid, bus.imem_addr, bus.state); else passed++;
      bus.dec_ready = 1'b1;
      step();
      checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 12'h100 || bus.dec_instr !== 32'hAAAA_0013)
         $display("FAIL rf_n2 got v=%b pc=%h instr=%h exp 1/100/aaaa0013", bus.dec_valid, bus.dec_pc, bus.dec_instr); else passed++;
      $display("test_redirect_full done");
   endtask

   task automatic test_halted_redirect();
      // Continues from the redirect test: 0x104 is zero, so the core halts.
      step(); step();
      checks++; if (bus.halted !== 1'b1 || bus.state !== 2'd3)
         $display("FAIL hr_halted got halted=%b state=%0d exp 1/3", bus.halted, bus.state); else passed++;
      mem[12'h040 >> 2] = 32'h0123_4513;
      mem[12'h044 >> 2] = 32'h0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 12'h040;
      step();
      bus.redirect_valid = 1'b0;
      checks++; if (bus.halted !== 1'b0 || bus.state !== 2'd1 || bus.imem_addr !== 12'h040)
         $display("FAIL hr_resume got halted=%b state=%0d addr=%h exp 0/1/040", bus.halted, bus.state, bus.imem_addr); else passed++;
      step();
      checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 12'h040 || bus.dec_instr !== 32'h0123_4513)
         $display("FAIL hr_first got v=%b pc=%h instr=%h exp 1/040/01234513", bus.dec_valid, bus.dec_pc, bus.dec_instr); else passed++;
      $display("test_halted_redirect done");
   endtask

   task automatic test_wrap();
      mem[1023] = 32'h00A0_0093;
      bus.dec_ready = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 12'hFFC;
      step();
      bus.redirect_valid = 1'b0;
      checks++; if (bus.imem_addr !== 12'hFFC) $display("FAIL wrap_addr got=%h exp ffc", bus.imem_addr); else passed++;
      step();
      checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 12'hFFC || bus.dec_instr !== 32'h00A0_0093)
         $display("FAIL wrap_ffc got v=%b pc=%h instr=%h exp 1/ffc/00a00093", bus.dec_valid, bus.dec_pc, bus.dec_instr); else passed++;
      step();
      checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 12'h000 || bus.dec_instr !== 32'h1000_0013)
         $display("FAIL wrap_000 got v=%b pc=%h instr=%h exp 1/000/10000013", bus.dec_valid, bus.dec_pc, bus.dec_instr); else passed++;
      $display("test_wrap done");
   endtask

   task automatic test_redirect_boot();
      bus.dec_ready = 1'b1;
      do_reset();   // E0: BOOT
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 12'h041;
      step();
      bus.redirect_valid = 1'b0;
      checks++; if (bus.state !== 2'd1 || bus.imem_addr !== 12'h040 || bus.dec_valid !== 1'b0)
         $display("FAIL boot_redir got state=%0d addr=%h v=%b exp 1/040/0", bus.state, bus.imem_addr, bus.dec_valid); else passed++;
      step();
      checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 12'h040)
         $display("FAIL boot_redir_dec got v=%b pc=%h exp 1/040", bus.dec_valid, bus.dec_pc); else passed++;
      $display("test_redirect_boot done");
   endtask

   task automatic test_reset_mid();
      bus.dec_ready = 1'b0;
      do_reset();
      step(); step(); step(); // E3: queue full
      checks++; if (bus.dec_valid !== 1'b1 || bus.imem_addr !== 12'h008)
         $display("FAIL rm_full got v=%b addr=%h exp 1/008", bus.dec_valid, bus.imem_addr); else passed++;
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (bus.dec_valid !== 1'b0 || bus.state !== 2'd0 || bus.imem_addr !== 12'h000)
         $display("FAIL rm_after got v=%b state=%0d addr=%h exp 0/0/000", bus.dec_valid, bus.state, bus.imem_addr); else passed++;
      $display("test_reset_mid done");
   endtask

   initial begin
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 12'h0;
      bus.dec_ready = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_full();
      test_halted_redirect();
      test_wrap();
      test_redirect_boot();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
